// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with input FIFO and exact-count baud divider
// clk, rst         : clock, synchronous active-high reset
// tx_valid/tx_data : host write port; a word is taken on an edge with tx_valid & tx_ready
// tx_ready         : FIFO not full (low while rst is high)
// txd              : registered serial output, idle high
// tx_busy          : frame on the wire or words queued
// tx_done          : one-cycle pulse on the last cycle of each frame's final stop bit
// fifo_level       : words queued, excluding the frame on the wire
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 66000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(STOP_BITS * DIV);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CLK_FREQ < 8 * BAUD) begin : g_err_clk
    $error("uart_tx_fifo: CLK_FREQ must be at least 8*BAUD");
  end
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t                 state;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          count;
  logic [DATA_BITS-1:0]   sh, head;
  logic [CW-1:0]          cnt, lim;
  logic [3:0]             idx;
  logic                   par, head_par, wr, pop, empty, bit_end;
  assign empty      = count == '0;
  assign tx_ready   = !rst && count != LW'(FIFO_DEPTH);
  assign wr         = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign head_par   = (^head) ^ (PARITY == 1);
  // the stop phase is timed as one long bit so a single counter covers every state
  assign lim        = state == S_STOP ? CW'(STOP_BITS * DIV - 1) : CW'(DIV - 1);
  assign bit_end    = cnt == lim;
  // pop in IDLE, or on the final stop edge so the next start bit follows with no gap
  assign pop        = !empty && (state == S_IDLE || (state == S_STOP && bit_end));
  assign fifo_level = count;
  assign tx_busy    = state != S_IDLE || !empty;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= tx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + LW'(wr) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      par     <= 1'b0;
      txd     <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      // registered one cycle early so the pulse lands on the last stop cycle
      tx_done <= state == S_STOP && cnt == lim - CW'(1);
      cnt     <= (state == S_IDLE || bit_end) ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: if (pop) begin
          state <= S_START;
          sh    <= head;
          par   <= head_par;
          txd   <= 1'b0;
        end
        S_START: if (bit_end) begin
          state <= S_DATA;
          idx   <= '0;
          txd   <= sh[0];
        end
        S_DATA: if (bit_end) begin
          idx <= idx + 4'd1;
          sh  <= sh >> 1;
          if (idx == 4'(DATA_BITS - 1)) begin
            state <= PARITY != 0 ? S_PAR : S_STOP;
            txd   <= PARITY != 0 ? par : 1'b1;
          end else
            txd <= sh[1];
        end
        S_PAR: if (bit_end) begin
          state <= S_STOP;
          txd   <= 1'b1;
        end
        S_STOP: if (bit_end) begin
          state <= pop ? S_START : S_IDLE;
          txd   <= !pop;
          if (pop) begin
            sh  <= head;
            par <= head_par;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (8N1, 7E1, 7O1, 9N2 at DIV=16)
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [8:0] dat;
  logic [3:0] rdy, txd_v, busy_v, done_v;
  logic [2:0] lvl0, lvl1, lvl2, lvl3;
  int         n_assert = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[7:0]), .tx_ready(rdy[0]),
    .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .fifo_level(lvl0));
  uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u7e (
    .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[6:0]), .tx_ready(rdy[1]),
    .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .fifo_level(lvl1));
  uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u7o (
    .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[6:0]), .tx_ready(rdy[2]),
    .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .fifo_level(lvl2));
  uart_tx_fifo #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u9 (
    .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat), .tx_ready(rdy[3]),
    .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]), .fifo_level(lvl3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // expected 8N1 line level for bit slot b (0 start, 1..8 data LSB first, 9 stop)
  function automatic logic fbit8(input logic [7:0] d, input int b);
    return b == 0 ? 1'b0 : b > 8 ? 1'b1 : d[b-1];
  endfunction
  // write one word into idle instance w, then check the whole frame cycle by cycle
  task automatic frame(input int w, input logic [8:0] data, input logic [15:0] seq, input int nb, input string tag);
    vld[w] = 1'b1;
    dat    = data;
    chk({tag, " ready"}, 32'(rdy[w]), 1);
    tick();
    vld[w] = 1'b0;
    chk({tag, " busy_after_accept"}, 32'(busy_v[w]), 1);
    chk({tag, " txd_before_start"}, 32'(txd_v[w]), 1);
    tick();
    for (int k = 0; k < nb * 16; k++) begin
      chk($sformatf("%s txd k=%0d", tag, k), 32'(txd_v[w]), 32'(seq[k/16]));
      chk($sformatf("%s done k=%0d", tag, k), 32'(done_v[w]), 32'(k == nb * 16 - 1));
      tick();
    end
    chk({tag, " busy_after_frame"}, 32'(busy_v[w]), 0);
    chk({tag, " txd_idle"}, 32'(txd_v[w]), 1);
    chk({tag, " done_cleared"}, 32'(done_v[w]), 0);
  endtask
  initial begin
    rst = 1'b1;
    vld = '0;
    dat = '0;
    tick();
    tick();
    chk("reset txd", 32'(txd_v), 32'hF);
    chk("reset busy", 32'(busy_v), 0);
    chk("reset done", 32'(done_v), 0);
    chk("reset ready_low", 32'(rdy), 0);
    chk("reset levels", {20'd0, lvl3, lvl2, lvl1, lvl0}, 0);
    rst = 1'b0;
    tick();
    chk("post_reset ready", 32'(rdy), 32'hF);
    // single 8N1 frame of 0x55
    frame(0, 9'h055, {6'd0, 1'b1, 8'h55, 1'b0}, 10, "t1_8n1_55");
    // 7-bit 0x41 has two ones: even parity bit 0, odd parity bit 1
    frame(1, 9'h041, {6'd0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, "t2_7e1_41");
    frame(2, 9'h041, {6'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, "t2_7o1_41");
    // 9N2 all ones: start, nine ones, two stop bits
    frame(3, 9'h1FF, {4'd0, 2'b11, 9'h1FF, 1'b0}, 12, "t5_9n2_1ff");
    // six-cycle burst of 0..5 into depth-4 FIFO: 0..4 taken, 5 refused
    vld[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dat = 9'(i);
      chk($sformatf("t3 ready before edge %0d", i), 32'(rdy[0]), 32'(i < 5));
      tick();
      chk($sformatf("t3 level after edge %0d", i), 32'(lvl0), i == 0 ? 1 : i == 1 ? 1 : i == 5 ? 4 : i);
    end
    // keep offering word 5 until the pop at the end of frame 0: it must still be refused
    for (int k = 4; k < 800; k++) begin
      chk($sformatf("t3 txd k=%0d", k), 32'(txd_v[0]), 32'(fbit8(8'(k / 160), (k % 160) / 16)));
      chk($sformatf("t3 done k=%0d", k), 32'(done_v[0]), 32'(k % 160 == 159));
      if (k == 159) begin
        chk("t6 ready_full_at_pop", 32'(rdy[0]), 0);
        chk("t6 level_full_at_pop", 32'(lvl0), 4);
      end
      if (k == 160) begin
        chk("t6 ready_after_pop", 32'(rdy[0]), 1);
        chk("t6 level_after_pop", 32'(lvl0), 3);
        vld[0] = 1'b0;
      end
      tick();
    end
    chk("t3 busy_end", 32'(busy_v[0]), 0);
    chk("t3 txd_end", 32'(txd_v[0]), 1);
    chk("t3 level_end", 32'(lvl0), 0);
    // reset during data bit 3 of 0xA5
    vld[0] = 1'b1;
    dat    = 9'h0A5;
    tick();
    vld[0] = 1'b0;
    tick();
    repeat (70) tick();
    chk("t4 txd_bit3_before_reset", 32'(txd_v[0]), 0);
    rst = 1'b1;
    tick();
    chk("t4 txd_at_reset", 32'(txd_v[0]), 1);
    chk("t4 done_at_reset", 32'(done_v[0]), 0);
    chk("t4 level_at_reset", 32'(lvl0), 0);
    chk("t4 busy_at_reset", 32'(busy_v[0]), 0);
    chk("t4 ready_in_reset", 32'(rdy[0]), 0);
    rst = 1'b0;
    tick();
    chk("t4 ready_after_reset", 32'(rdy[0]), 1);
    for (int k = 0; k < 150; k++) begin
      chk($sformatf("t4 no_done k=%0d", k), 32'(done_v[0]), 0);
      chk($sformatf("t4 txd_high k=%0d", k), 32'(txd_v[0]), 1);
      tick();
    end
    frame(0, 9'h03C, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, "t4_8n1_3c");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N2 transmitter in the MAX V UART test design. Adds:
- configurable data width, parity mode and stop-bit count
- an internal exact-count baud divider
- a small input FIFO with valid/ready handshake, so host logic can queue words and get back-to-back frames with no idle gap.

Sits between the host/command logic and the TxD pin.

Parameters:
CLK_FREQ, 66000000, input clock frequency in Hz
BAUD, 9600, line rate in bits/s
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 2, legal 1 or 2
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
tx_valid  in  1  host offers tx_data this cycle
tx_data  in  DATA_BITS  word to transmit, LSB sent first
tx_ready  out  1  FIFO can accept; a write occurs on an edge where tx_valid & tx_ready
txd  out  1  serial line, idle high, registered output
tx_busy  out  1  frame in progress or FIFO non-empty
tx_done  out  1  one-cycle pulse at end of each frame's last stop bit
fifo_level  out  clog2(FIFO_DEPTH)+1  words currently queued, not including the frame on the wire

Behaviour:
- Elaboration errors:
  - DATA_BITS outside 5..9
  - PARITY > 2
  - STOP_BITS not 1 or 2
  - FIFO_DEPTH not a power of two or < 2
  - CLK_FREQ < 8*BAUD
- Bit period: DIV = (CLK_FREQ + BAUD/2) / BAUD clocks, integer-rounded.
  - Baud counter is cleared at every frame start, so every bit, including the start bit, lasts exactly DIV cycles.
  - The counter does not run in IDLE.
- Reset (rst high at an edge):
  - After that edge: txd=1, tx_busy=0, tx_done=0, fifo_level=0; FSM in IDLE; FIFO flushed.
  - tx_ready=0 while rst is high and 1 on the first cycle after rst deasserts.
  - Reset mid-frame aborts the frame; txd is high from the reset edge on; no tx_done.
- FIFO:
  - tx_ready = !full.
  - Writes with tx_ready low are ignored; tx_data need not be held after the accepting edge.
  - Simultaneous write and pop on the same edge are both honoured; level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If FIFO non-empty, pop the head into the shift register, go to START.
  - START: txd=0 for DIV cycles, then DATA.
  - DATA: bit index 0..DATA_BITS-1, LSB first, DIV cycles each. After the last bit go to PARITY if PARITY!=0, else STOP.
  - PARITY: even sends XOR of the data bits; odd sends its inverse. Lasts DIV cycles.
  - STOP: txd=1 for STOP_BITS*DIV cycles.
  - End of STOP:
    - tx_done=1 for exactly one cycle, coincident with the last cycle of the final stop bit.
    - If FIFO non-empty: pop on that same edge and go directly to START; txd falls on the next cycle, with zero idle cycles between frames.
    - Otherwise go to IDLE.
- Latency: a word accepted at edge E0 into an empty FIFO with FSM idle is popped at E1. txd is low from E1, so the start bit is visible one cycle after acceptance.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- tx_busy = (state != IDLE) | (fifo_level != 0). It goes high the cycle after acceptance and drops the cycle after the final tx_done when the FIFO is empty.
- txd is driven from a flop only, with no combinational path from inputs.

Test Plan:
1. CLK_FREQ=1600000, BAUD=100000 (DIV=16), 8N1. Write 0x55 -> txd low 16 clocks starting 1 cycle after accept; then 1,0,1,0,1,0,1,0 at 16 clocks each; high 16; tx_done pulses once at cycle 160 of the frame; tx_busy drops the next cycle.
2. DATA_BITS=7, PARITY=2. Send 0x41 -> parity bit 0. Rebuild with PARITY=1 -> parity bit 1. Frame is 10*DIV clocks with STOP_BITS=1.
3. FIFO_DEPTH=4. Hold tx_valid for 6 consecutive cycles -> words 0..4 accepted (first popped at E1), tx_ready low from E5, fifo_level peaks at 4. Five frames go out back-to-back with no idle cycle between stop and start, in order, with exactly five tx_done pulses.
4. Assert rst for one cycle during DATA bit 3 of 0xA5 -> txd high from the reset edge, no tx_done, fifo_level=0. A new 0x3C is then sent correctly from a full-length start bit.
5. DATA_BITS=9, STOP_BITS=2, PARITY=0. Send 0x1FF -> start, nine 1s, high for 2*DIV cycles; frame is 12*DIV cycles.
6. Write into a full FIFO on the same edge the FSM pops -> the write is refused (tx_ready was low); on the next cycle tx_ready=1 and fifo_level=FIFO_DEPTH-1.
